// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - command codes, FSM states and timer sizing for mem_ctrl_param
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_WAIT_RCD,
        S_RDWR,
        S_WAIT_CAS,
        S_PRE,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC
    } state_e;

    function automatic int timer_width(input int trcd, input int tcas, input int trp, input int trfc);
        int m;
        m = trcd;
        if (tcas > m) m = tcas;
        if (trp > m) m = trp;
        if (trfc > m) m = trfc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mem_refresh_timer.sv
// rtl/mem_refresh_timer.sv - free-running refresh interval counter with sticky pending flag
module mem_refresh_timer #(
    parameter int REF_INTERVAL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_ack,
    output logic ref_pending
);

    localparam int CNT_W = $clog2(REF_INTERVAL);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_INTERVAL - 1);

    logic [CNT_W-1:0] cnt;

    // An expiry in the same cycle as the acknowledge wins, so no interval is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            ref_pending <= 1'b0;
        end else if (cnt == LAST) begin
            cnt         <= '0;
            ref_pending <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            if (ref_ack) ref_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_ctrl_param.sv
// rtl/mem_ctrl_param.sv - single-rank memory controller with open-row tracking and refresh
module mem_ctrl_param
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int RA_W         = 4,
    parameter int CA_W         = 12,
    parameter int ADDR_W       = RA_W + CA_W,
    parameter int TRCD         = 2,
    parameter int TCAS         = 3,
    parameter int TRP          = 2,
    parameter int TRFC         = 4,
    parameter int REF_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_n,
    input  logic              RDnWR,
    input  logic              Data_in_vld,
    input  logic [ADDR_W-1:0] Addr_in,
    input  logic [DATA_W-1:0] Data_in,
    output logic              cmd_rdy,
    inout  wire  [DATA_W-1:0] DQ,
    output logic [DATA_W-1:0] Data_out,
    output logic              data_out_vld,
    output logic              wr_err,
    output logic [2:0]        command,
    output logic [RA_W-1:0]   RA,
    output logic [CA_W-1:0]   CA,
    output logic              cs_n
);

    localparam int TMR_W = timer_width(TRCD, TCAS, TRP, TRFC);
    localparam logic [TMR_W-1:0] RCD_LD = TMR_W'(TRCD - 2);
    localparam logic [TMR_W-1:0] CAS_LD = TMR_W'(TCAS - 1);
    localparam logic [TMR_W-1:0] RP_LD  = TMR_W'(TRP - 2);
    localparam logic [TMR_W-1:0] RFC_LD = TMR_W'(TRFC - 2);

    state_e            state;
    cmd_e              cmd_q;
    logic [TMR_W-1:0]  tmr;
    logic              started;
    logic              row_open;
    logic [RA_W-1:0]   open_row;
    logic [RA_W-1:0]   req_ra;
    logic [CA_W-1:0]   req_ca;
    logic              req_rd;
    logic [DATA_W-1:0] req_data;
    logic              ref_busy;
    logic              dq_oe;
    logic [DATA_W-1:0] dq_out;
    logic              ref_pending;
    logic              ref_ack;
    logic              accept;
    logic              wait_done;
    logic [RA_W-1:0]   addr_ra;
    logic [CA_W-1:0]   addr_ca;

    mem_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref (
        .clk         (clk),
        .rst         (rst),
        .ref_ack     (ref_ack),
        .ref_pending (ref_pending)
    );

    assign addr_ra = Addr_in[ADDR_W-1 -: RA_W];
    assign addr_ca = Addr_in[CA_W-1:0];
    assign cmd_rdy = started && (state == S_IDLE) && !ref_pending;
    assign accept  = !cmd_n && cmd_rdy;
    assign ref_ack = (state == S_REF);
    assign command = cmd_q;
    assign DQ      = dq_oe ? dq_out : {DATA_W{1'bz}};

    // Command states end their wait immediately when the timing parameter is 1.
    always_comb begin
        wait_done = 1'b0;
        unique case (state)
            S_ACT:                                          wait_done = (TRCD == 1);
            S_PRE:                                          wait_done = (TRP == 1);
            S_REF:                                          wait_done = (TRFC == 1);
            S_WAIT_RCD, S_WAIT_CAS, S_WAIT_RP, S_WAIT_RFC:  wait_done = (tmr == '0);
            default:                                        wait_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cmd_q        <= CMD_NOP;
            RA           <= '0;
            CA           <= '0;
            cs_n         <= 1'b1;
            Data_out     <= '0;
            data_out_vld <= 1'b0;
            wr_err       <= 1'b0;
            started      <= 1'b0;
            row_open     <= 1'b0;
            open_row     <= '0;
            tmr          <= '0;
            dq_oe        <= 1'b0;
            dq_out       <= '0;
            req_ra       <= '0;
            req_ca       <= '0;
            req_rd       <= 1'b0;
            req_data     <= '0;
            ref_busy     <= 1'b0;
        end else begin
            started      <= 1'b1;
            cmd_q        <= CMD_NOP;
            RA           <= '0;
            CA           <= '0;
            cs_n         <= 1'b1;
            data_out_vld <= 1'b0;
            wr_err       <= 1'b0;
            dq_oe        <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (ref_pending) begin
                        ref_busy <= 1'b1;
                        cs_n     <= 1'b0;
                        if (row_open) begin
                            state    <= S_PRE;
                            cmd_q    <= CMD_PRE;
                            row_open <= 1'b0;
                        end else begin
                            state <= S_REF;
                            cmd_q <= CMD_REF;
                        end
                    end else if (accept) begin
                        req_ra   <= addr_ra;
                        req_ca   <= addr_ca;
                        req_rd   <= RDnWR;
                        req_data <= Data_in;
                        if (!RDnWR && !Data_in_vld) begin
                            wr_err <= 1'b1;
                        end else if (row_open && open_row == addr_ra) begin
                            state  <= S_RDWR;
                            cmd_q  <= RDnWR ? CMD_RD : CMD_WR;
                            cs_n   <= 1'b0;
                            CA     <= addr_ca;
                            dq_oe  <= !RDnWR;
                            dq_out <= Data_in;
                        end else if (row_open) begin
                            state    <= S_PRE;
                            cmd_q    <= CMD_PRE;
                            cs_n     <= 1'b0;
                            row_open <= 1'b0;
                        end else begin
                            state    <= S_ACT;
                            cmd_q    <= CMD_ACT;
                            cs_n     <= 1'b0;
                            RA       <= addr_ra;
                            row_open <= 1'b1;
                            open_row <= addr_ra;
                        end
                    end
                end
                S_ACT, S_WAIT_RCD: begin
                    if (wait_done) begin
                        state  <= S_RDWR;
                        cmd_q  <= req_rd ? CMD_RD : CMD_WR;
                        cs_n   <= 1'b0;
                        CA     <= req_ca;
                        dq_oe  <= !req_rd;
                        dq_out <= req_data;
                    end else if (state == S_ACT) begin
                        state <= S_WAIT_RCD;
                        tmr   <= RCD_LD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_RDWR: begin
                    if (req_rd) begin
                        state <= S_WAIT_CAS;
                        tmr   <= CAS_LD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT_CAS: begin
                    if (wait_done) begin
                        Data_out     <= DQ;
                        data_out_vld <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_PRE, S_WAIT_RP: begin
                    if (wait_done) begin
                        cs_n <= 1'b0;
                        if (ref_busy) begin
                            state <= S_REF;
                            cmd_q <= CMD_REF;
                        end else begin
                            state    <= S_ACT;
                            cmd_q    <= CMD_ACT;
                            RA       <= req_ra;
                            row_open <= 1'b1;
                            open_row <= req_ra;
                        end
                    end else if (state == S_PRE) begin
                        state <= S_WAIT_RP;
                        tmr   <= RP_LD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_REF, S_WAIT_RFC: begin
                    if (wait_done) begin
                        state    <= S_IDLE;
                        ref_busy <= 1'b0;
                    end else if (state == S_REF) begin
                        state <= S_WAIT_RFC;
                        tmr   <= RFC_LD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
